// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle program-counter sequencer.
// Walks FETCH -> DECODE -> EXECUTE -> WRITEBACK for each instruction.
// Jumps (j/jal/jr) resolve in DECODE and branches (beq/bne) resolve in EXECUTE.
// All other opcodes retire in WRITEBACK with PC+4.
// The halt opcode parks the sequencer in HALT until Reset.
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned jr targets into HALT.
//   Without it, jr loads rsData unmodified.
// Handshake: instrValid=1 marks instr valid for this cycle. It is only consumed
//   in FETCH, where it captures instr into IR and advances to DECODE. The sequencer
//   has no ready output, because it is always ready in FETCH and ignores instr elsewhere.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] instr,
  input  logic        instrValid,
  input  logic        zero,
  input  logic [31:0] rsData,
  output logic [31:0] PC,
  output logic [31:0] origin,
  output logic [31:0] withOffset,
  output logic [31:0] immediate,
  output logic [31:0] inRegister,
  output logic [1:0]  PCSrc,
  output logic        PCWrite,
  output logic [2:0]  stage,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [1:0] SRC_ORIGIN = 2'b00;
  localparam logic [1:0] SRC_OFFSET = 2'b01;
  localparam logic [1:0] SRC_REG    = 2'b10;
  localparam logic [1:0] SRC_IMM    = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        pc_write;
  logic [1:0]  pc_src;

  // Instruction decode, always taken from the latched IR.
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_jump, is_jr, is_halt, is_beq, is_bne, is_branch, br_taken, jr_bad;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign is_jump   = (opcode == 6'b000010) || (opcode == 6'b000011);
  assign is_jr     = (opcode == 6'b000000) && (funct == 6'b001000);
  assign is_halt   = (opcode == 6'b111111);
  assign is_beq    = (opcode == 6'b000100);
  assign is_bne    = (opcode == 6'b000101);
  assign is_branch = is_beq || is_bne;
  assign br_taken  = (is_beq && zero) || (is_bne && !zero);

`ifdef PC_ALIGN_CHECK_EN
  // A jr target that is not word aligned is treated as fatal.
  assign jr_bad = (rsData[1:0] != 2'b00);
`else
  assign jr_bad = 1'b0;
`endif

  // Candidate next addresses. All additions wrap modulo 2^32.
  assign origin     = pc_q + 32'd4;
  assign withOffset = origin + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign immediate  = {origin[31:28], ir_q[25:0], 2'b00};
  assign inRegister = rsData;

  // State, PC and IR registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic for the instruction sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     if (instrValid) state_d = S_DECODE;
      S_DECODE: begin
        if (is_jump || (is_jr && !jr_bad)) state_d = S_FETCH;
        else if (is_halt || (is_jr && jr_bad)) state_d = S_HALT;
        else state_d = S_EXECUTE;
      end
      S_EXECUTE:   state_d = is_branch ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // PC write strobe and source select. Both are forced to zero while Reset is high.
  always_comb begin
    pc_write = 1'b0;
    pc_src   = SRC_ORIGIN;
    unique case (state_q)
      S_DECODE: begin
        if (is_jump) begin
          pc_write = 1'b1;
          pc_src   = SRC_IMM;
        end else if (is_jr && !jr_bad) begin
          pc_write = 1'b1;
          pc_src   = SRC_REG;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = br_taken ? SRC_OFFSET : SRC_ORIGIN;
        end
      end
      S_WRITEBACK: pc_write = 1'b1;
      default: begin
        pc_write = 1'b0;
        pc_src   = SRC_ORIGIN;
      end
    endcase
    if (Reset) begin
      pc_write = 1'b0;
      pc_src   = SRC_ORIGIN;
    end
  end

  // Datapath next values: IR captures on an accepted fetch, and PC loads the selected target.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_FETCH && instrValid) ir_d = instr;
    pc_d = pc_q;
    if (pc_write) begin
      unique case (pc_src)
        SRC_ORIGIN: pc_d = origin;
        SRC_OFFSET: pc_d = withOffset;
        SRC_REG:    pc_d = inRegister;
        default:    pc_d = immediate;
      endcase
    end
  end

  assign PC      = pc_q;
  assign PCSrc   = pc_src;
  assign PCWrite = pc_write;
  assign stage   = state_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer, including the PC_ALIGN_CHECK_EN option.
// The reference model describes each instruction as a list of stages.
// It also records which stage writes the PC, the source used and the resulting target.
module tb_pc_sequencer;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] instr;
  logic        instrValid;
  logic        zero;
  logic [31:0] rsData;
  logic [31:0] PC, origin, withOffset, immediate, inRegister;
  logic [1:0]  PCSrc;
  logic        PCWrite;
  logic [2:0]  stage;
  logic        halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .Reset(Reset), .instr(instr), .instrValid(instrValid), .zero(zero),
    .rsData(rsData), .PC(PC), .origin(origin), .withOffset(withOffset),
    .immediate(immediate), .inRegister(inRegister), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .stage(stage), .halted(halted)
  );

  // Clock generation
  always #5 CLK = ~CLK;

  // Reset through one rising edge. The strobe must stay quiet while Reset is high.
  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1; instrValid = 1'($urandom_range(0, 1)); instr = $urandom;
    #1;
    n_checks++;
    if (PCWrite !== 1'b0 || PCSrc !== 2'b00) begin
      n_fail++; $display("FAIL reset_strobe: PCWrite=%b PCSrc=%b required 0/00", PCWrite, PCSrc);
    end
    @(negedge CLK);
    Reset = 1'b0; instrValid = 1'b0;
    m_pc = RST_PC;
    #1;
    n_checks++;
    if (PC !== RST_PC || stage !== 3'd0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: PC=%h stage=%0d halted=%b required %h/0/0", PC, stage, halted, RST_PC);
    end
  endtask

  // Execute one instruction from FETCH and compare each cycle with the model.
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic [31:0] rs);
    logic [5:0]  op, fn;
    logic [31:0] pc4, tgt, exp_imm, exp_off;
    logic [2:0]  seq[$];
    logic [1:0]  src;
    int          wr_at;
    bit          to_halt;
    op = ins[31:26]; fn = ins[5:0];
    pc4 = m_pc + 32'd4;
    exp_imm = {pc4[31:28], ins[25:0], 2'b00};
    exp_off = pc4 + 32'({{14{ins[15]}}, ins[15:0], 2'b00});
    seq = '{3'd0, 3'd1}; wr_at = -1; src = 2'b00; tgt = m_pc; to_halt = 0;
    if (op == 6'd2 || op == 6'd3) begin
      wr_at = 1; src = 2'b11; tgt = exp_imm;
    end else if (op == 6'd0 && fn == 6'd8) begin
      if (ALIGN && rs[1:0] != 2'b00) to_halt = 1;
      else begin wr_at = 1; src = 2'b10; tgt = rs; end
    end else if (op == 6'd63) begin
      to_halt = 1;
    end else if (op == 6'd4 || op == 6'd5) begin
      seq.push_back(3'd2); wr_at = 2;
      if ((op == 6'd4) ? z : !z) begin src = 2'b01; tgt = exp_off; end
      else tgt = pc4;
    end else begin
      seq.push_back(3'd2); seq.push_back(3'd3); wr_at = 3; tgt = pc4;
    end
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge CLK);
      zero = z; rsData = rs;
      if (i == 0) begin instrValid = 1'b1; instr = ins; end
      else begin instrValid = 1'($urandom_range(0, 1)); instr = $urandom; end
      #1;
      n_checks++;
      if (stage !== seq[i] || PCWrite !== (i == wr_at) || PCSrc !== ((i == wr_at) ? src : 2'b00)
          || PC !== m_pc || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL step%0d ins=%h: stage=%0d PCWrite=%b PCSrc=%b PC=%h halted=%b required %0d/%b/%b/%h/0",
                 i, ins, stage, PCWrite, PCSrc, PC, halted, seq[i], (i == wr_at),
                 (i == wr_at) ? src : 2'b00, m_pc);
      end
      if (i == 1) begin
        n_checks++;
        if (origin !== pc4 || immediate !== exp_imm || withOffset !== exp_off || inRegister !== rs) begin
          n_fail++;
          $display("FAIL addr_outputs ins=%h: origin=%h imm=%h off=%h inReg=%h required %h/%h/%h/%h",
                   ins, origin, immediate, withOffset, inRegister, pc4, exp_imm, exp_off, rs);
        end
      end
    end
    if (wr_at >= 0) m_pc = tgt;
    @(negedge CLK);
    instrValid = 1'b0;
    #1;
    n_checks++;
    if (PC !== m_pc || stage !== (to_halt ? 3'd4 : 3'd0) || halted !== to_halt) begin
      n_fail++;
      $display("FAIL retire ins=%h: PC=%h stage=%0d halted=%b required %h/%0d/%b",
               ins, PC, stage, halted, m_pc, to_halt ? 4 : 0, to_halt);
    end
  endtask

  // Reset state, plus reset taking priority over a jump that is mid-instruction.
  task automatic test_reset();
    Reset = 1'b1; instrValid = 1'b0; instr = '0; zero = 1'b0; rsData = '0;
    repeat (2) @(posedge CLK);
    do_reset();
    @(negedge CLK);
    instrValid = 1'b1; instr = 32'h0800_0123;
    @(negedge CLK);
    instrValid = 1'b0; Reset = 1'b1;
    #1;
    n_checks++;
    if (stage !== 3'd1 || PCWrite !== 1'b0 || PCSrc !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_instr: stage=%0d PCWrite=%b PCSrc=%b required 1/0/00", stage, PCWrite, PCSrc);
    end
    do_reset();
  endtask

  // An add walks through all four stages and advances the PC by 4.
  task automatic test_add();
    do_reset();
    run_instr(32'h0000_0020, 1'b0, 32'h0);
  endtask

  // beq with offset 3 from PC=8, both taken and not taken.
  task automatic test_branch();
    do_reset();
    run_instr(32'h0000_0020, 1'b0, 32'h0);
    run_instr(32'h0000_0020, 1'b0, 32'h0);
    run_instr(32'h1022_0003, 1'b1, 32'h0);
    n_checks++;
    if (PC !== 32'd24) begin n_fail++; $display("FAIL beq_taken: PC=%h required %h", PC, 32'd24); end
    do_reset();
    run_instr(32'h0000_0020, 1'b0, 32'h0);
    run_instr(32'h0000_0020, 1'b0, 32'h0);
    run_instr(32'h1022_0003, 1'b0, 32'h0);
    n_checks++;
    if (PC !== 32'd12) begin n_fail++; $display("FAIL beq_not_taken: PC=%h required %h", PC, 32'd12); end
  endtask

  // j from PC=0x1000_0000 keeps the top nibble of PC+4.
  task automatic test_jump();
    run_instr(32'h0020_0008, 1'b0, 32'h1000_0000);
    run_instr(32'h0800_0010, 1'b0, 32'h0);
    n_checks++;
    if (PC !== 32'h1000_0040) begin n_fail++; $display("FAIL j_target: PC=%h required %h", PC, 32'h1000_0040); end
  endtask

  // With no valid instruction, FETCH holds and the PC is not written.
  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      instrValid = 1'b0; instr = $urandom;
      #1;
      n_checks++;
      if (stage !== 3'd0 || PC !== m_pc || PCWrite !== 1'b0) begin
        n_fail++; $display("FAIL stall%0d: stage=%0d PC=%h PCWrite=%b required 0/%h/0", i, stage, PC, PCWrite, m_pc);
      end
    end
  endtask

  // PC+4 wraps to zero at the top of the address space.
  task automatic test_wrap();
    run_instr(32'h0020_0008, 1'b0, 32'hFFFF_FFFC);
    n_checks++;
    if (origin !== 32'h0) begin n_fail++; $display("FAIL wrap_origin: origin=%h required 00000000", origin); end
    run_instr(32'h0000_0020, 1'b0, 32'h0);
  endtask

  // jr to a misaligned target.
  task automatic test_jr_misaligned();
    logic [31:0] pc_before;
    do_reset();
    pc_before = m_pc;
    run_instr(32'h0020_0008, 1'b0, 32'h0000_0102);
    n_checks++;
    if (ALIGN ? (halted !== 1'b1 || PC !== pc_before) : (halted !== 1'b0 || PC !== 32'h0000_0102)) begin
      n_fail++; $display("FAIL jr_misaligned: PC=%h halted=%b align=%b", PC, halted, ALIGN);
    end
    do_reset();
  endtask

  // The halt opcode freezes the sequencer until Reset.
  task automatic test_halt_reset();
    run_instr(32'h0000_0020, 1'b0, 32'h0);
    run_instr(32'hFC00_0000, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      instrValid = 1'b1; instr = $urandom; zero = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (stage !== 3'd4 || halted !== 1'b1 || PC !== m_pc || PCWrite !== 1'b0 || PCSrc !== 2'b00) begin
        n_fail++; $display("FAIL halt_hold%0d: stage=%0d halted=%b PC=%h PCWrite=%b required 4/1/%h/0", i, stage, halted, PC, PCWrite, m_pc);
      end
    end
    do_reset();
  endtask

  // Random instruction mix with random stalls between fetches.
  task automatic test_random();
    logic [31:0] ins, rs;
    logic [5:0]  ops[9];
    ops = '{6'd0, 6'd2, 6'd3, 6'd0, 6'd63, 6'd4, 6'd5, 6'd35, 6'd8};
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 8);
      ins = $urandom;
      ins[31:26] = ops[k];
      if (k == 0) ins[5:0] = 6'h20;
      if (k == 3) ins[5:0] = 6'h08;
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK); instrValid = 1'b0;
      end
      run_instr(ins, 1'($urandom_range(0, 1)), rs);
      if (halted) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_jr_misaligned();
    test_halt_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
